// File: rtl/mc_main_control_if.sv
// Controller-to-datapath bundle for the multi-cycle main control FSM:
// the opcode/memory-ready inputs and every control strobe or select it drives.
interface mc_main_control_if;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] Aluop;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic [3:0] state_dbg;

    // Controller side
    modport slave (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, Aluop,
               PCSource, illegal_op, state_dbg
    );

    // Datapath side
    modport master (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, Aluop,
               PCSource, illegal_op, state_dbg
    );
endinterface

// File: rtl/mc_main_control.sv
// Moore-style main control FSM for a multi-cycle MIPS-like datapath.
// Memory states optionally stall on mem_ready; DECODE flags unsupported opcodes.
module mc_main_control #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    mc_main_control_if.slave   bus
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEMADR    = 4'd3,
        MEMRD     = 4'd4,
        MEMWB     = 4'd5,
        MEMWR     = 4'd6,
        EXEC      = 4'd7,
        ALUWB     = 4'd8,
        BRANCH    = 4'd9,
        ADDIEX    = 4'd10,
        ADDIWB    = 4'd11,
        ORIEX     = 4'd12,
        ORIWB     = 4'd13,
        JUMP      = 4'd14,
        UNUSED_ST = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ORI   = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    state_t state;
    state_t state_next;

    logic ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;

    // With the handshake disabled every memory access completes in one cycle.
    assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        illegal       = 1'b0;

        case (state)
            IDLE: begin
                state_next = FETCH;
            end

            // PC+4 is computed every FETCH cycle but only committed with the IR.
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end

            // Branch target is precomputed here so BRANCH only has to compare.
            DECODE: begin
                alu_src_b = SRCB_BOFS;
                case (bus.opcode)
                    OP_RTYPE:      state_next = EXEC;
                    OP_LW, OP_SW:  state_next = MEMADR;
                    OP_BEQ:        state_next = BRANCH;
                    OP_ADDI:       state_next = ADDIEX;
                    OP_ORI:        state_next = ORIEX;
                    OP_J:          state_next = JUMP;
                    default: begin
                        illegal    = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end

            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            end

            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (ready) begin
                    state_next = MEMWB;
                end
            end

            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = FETCH;
            end

            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (ready) begin
                    state_next = FETCH;
                end
            end

            EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_FUNCT;
                state_next = ALUWB;
            end

            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = FETCH;
            end

            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_ALUOUT;
                state_next    = FETCH;
            end

            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = ADDIWB;
            end

            ORIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_ORI;
                state_next = ORIWB;
            end

            ADDIWB, ORIWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end

            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JUMP;
                state_next = FETCH;
            end

            // The spare encoding behaves like IDLE so a corrupted state recovers.
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = i_or_d;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegDst      = reg_dst;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.Aluop       = alu_op;
    assign bus.PCSource    = pc_source;
    assign bus.illegal_op  = illegal;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: directed scenarios plus random
// instruction streams checked against a per-instruction state-path model.
module tb_mc_main_control;

    localparam bit MEM_HANDSHAKE = 1'b1;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3,
                   S_MEMRD = 4, S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7,
                   S_ALUWB = 8, S_BRANCH = 9, S_ADDIEX = 10, S_ADDIWB = 11,
                   S_ORIEX = 12, S_ORIWB = 13, S_JUMP = 14;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mc_main_control_if bus ();

    mc_main_control #(.MEM_HANDSHAKE(MEM_HANDSHAKE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                  bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                  bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.Aluop,
                  bus.PCSource, bus.illegal_op};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b001000, 6'b001101, 6'b000010};
    endfunction

    function automatic bit is_mem(input int st);
        return st == S_FETCH || st == S_MEMRD || st == S_MEMWR;
    endfunction

    // Control word each state must present, straight from the state table.
    function automatic logic [16:0] exp_outs(input int st, input logic rdy, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            S_FETCH: begin
                mrd = 1; asb = 2'b01;
                if (rdy || !MEM_HANDSHAKE) begin irw = 1; pcw = 1; end
            end
            S_DECODE: begin asb = 2'b11; ill = !legal(op); end
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mrd = 1; iord = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mwr = 1; iord = 1; end
            S_EXEC:   begin asa = 1; aop = 2'b10; end
            S_ALUWB:  begin rw = 1; rdst = 1; end
            S_BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            S_ADDIEX: begin asa = 1; asb = 2'b10; end
            S_ORIEX:  begin asa = 1; asb = 2'b10; aop = 2'b11; end
            S_ADDIWB, S_ORIWB: rw = 1;
            S_JUMP:   begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
    endfunction

    // Sequence of states an instruction walks through with no memory wait.
    task automatic get_path(input logic [5:0] op, output int p[$]);
        p = {};
        p.push_back(S_FETCH);
        p.push_back(S_DECODE);
        case (op)
            6'b000000: begin p.push_back(S_EXEC); p.push_back(S_ALUWB); end
            6'b100011: begin p.push_back(S_MEMADR); p.push_back(S_MEMRD); p.push_back(S_MEMWB); end
            6'b101011: begin p.push_back(S_MEMADR); p.push_back(S_MEMWR); end
            6'b000100: p.push_back(S_BRANCH);
            6'b001000: begin p.push_back(S_ADDIEX); p.push_back(S_ADDIWB); end
            6'b001101: begin p.push_back(S_ORIEX); p.push_back(S_ORIWB); end
            6'b000010: p.push_back(S_JUMP);
            default: ;
        endcase
    endtask

    task automatic step(input logic [5:0] op, input logic rdy, input logic rs);
        @(negedge clk);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        reset         = rs;
        #1;
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    // Directed run: state nibble k and ready bit k describe cycle k.
    task automatic dir_seq(input string tag, input logic [5:0] op, input int n,
                           input logic [63:0] sts, input logic [15:0] rdys);
        int st;
        for (int k = 0; k < n; k++) begin
            st = int'(sts[4*k +: 4]);
            step(op, rdys[k], 1'b0);
            chk($sformatf("%s_state%0d", tag, k), 32'(bus.state_dbg), 32'(st));
            chk($sformatf("%s_outs%0d", tag, k), 32'(obs), 32'(exp_outs(st, rdys[k], op)));
        end
    endtask

    task automatic run_random(input logic [5:0] op);
        int p[$];
        int i;
        int guard;
        logic rdy;
        logic [5:0] drv;
        get_path(op, p);
        i = 0;
        guard = 0;
        while (i < p.size() && guard < 64) begin
            rdy = ($urandom_range(0, 2) != 0);
            drv = (p[i] == S_DECODE || p[i] == S_MEMADR) ? op : 6'($urandom);
            step(drv, rdy, 1'b0);
            chk("rnd_state", 32'(bus.state_dbg), 32'(p[i]));
            chk("rnd_outs", 32'(obs), 32'(exp_outs(p[i], rdy, drv)));
            if (!(MEM_HANDSHAKE && is_mem(p[i]) && !rdy)) i++;
            guard++;
        end
        if (guard >= 64) begin
            checks++;
            errors++;
            $error("FAIL rnd_guard: observed %0d cycles expected completion", guard);
        end
    endtask

    localparam logic [5:0] OPS [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                       6'b001000, 6'b001101, 6'b000010};
    localparam int CYC [7] = '{4, 5, 4, 3, 4, 4, 3};

    initial begin
        int n;
        logic [5:0] op;
        errors = 0;
        checks = 0;
        bus.opcode = '0;
        bus.mem_ready = 1'b0;
        reset = 1'b1;

        // Reset and an R-type instruction: 0,1,2,7,8 then back to FETCH.
        step(6'd0, 1'b0, 1'b1);
        step(6'd0, 1'b1, 1'b1);
        chk("reset_state", 32'(bus.state_dbg), 32'(S_IDLE));
        chk("reset_outs", 32'(obs), 32'd0);
        dir_seq("rtype", 6'b000000, 5, 64'h87210, 16'h001F);
        peek();
        chk("rtype_back_fetch", 32'(bus.state_dbg), 32'(S_FETCH));

        // lw with two stalled cycles in MEMRD: 7 cycles in total.
        dir_seq("lw_wait", 6'b100011, 7, 64'h5444321, 16'h0067);
        peek();
        chk("lw_back_fetch", 32'(bus.state_dbg), 32'(S_FETCH));

        dir_seq("beq", 6'b000100, 3, 64'h921, 16'h0007);
        peek();
        chk("beq_back_fetch", 32'(bus.state_dbg), 32'(S_FETCH));

        dir_seq("ori", 6'b001101, 4, 64'hDC21, 16'h000F);
        peek();
        chk("ori_back_fetch", 32'(bus.state_dbg), 32'(S_FETCH));

        dir_seq("illegal", 6'b111111, 2, 64'h21, 16'h0003);
        peek();
        chk("illegal_next_state", 32'(bus.state_dbg), 32'(S_FETCH));
        chk("illegal_pulse_end", 32'(bus.illegal_op), 32'd0);

        // Reset while sw is stalled in MEMWR.
        dir_seq("sw_stall", 6'b101011, 4, 64'h6321, 16'h0007);
        step(6'b101011, 1'b0, 1'b1);
        chk("memwr_before_reset", 32'(bus.MemWrite), 32'd1);
        step(6'b101011, 1'b0, 1'b0);
        chk("memwr_reset_state", 32'(bus.state_dbg), 32'(S_IDLE));
        chk("memwr_reset_outs", 32'(obs), 32'd0);
        peek();
        chk("memwr_reset_fetch", 32'(bus.state_dbg), 32'(S_FETCH));

        // Reset wins over mem_ready in FETCH.
        step(6'b000000, 1'b1, 1'b1);
        chk("fetch_before_reset", 32'(bus.state_dbg), 32'(S_FETCH));
        step(6'b000000, 1'b1, 1'b0);
        chk("fetch_reset_state", 32'(bus.state_dbg), 32'(S_IDLE));
        chk("fetch_reset_outs", 32'(obs), 32'd0);
        peek();

        // Zero-wait cycle count per instruction class, measured on the DUT.
        for (int j = 0; j < 7; j++) begin
            n = 0;
            for (int c = 0; c < 20; c++) begin
                step(OPS[j], 1'b1, 1'b0);
                n++;
                peek();
                if (bus.state_dbg == 4'(S_FETCH)) break;
            end
            chk($sformatf("cycles_op%0h", OPS[j]), 32'(n), 32'(CYC[j]));
        end

        // Random instruction stream with random memory stalls.
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 7);
            op = (n == 7) ? 6'($urandom) : OPS[n];
            run_random(op);
        end
        peek();
        chk("final_fetch", 32'(bus.state_dbg), 32'(S_FETCH));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_main_control.md
MC_MAIN_CONTROL -- requirements
Module: mc_main_control

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1, meaning 1 = memory states wait for mem_ready and 0 = mem_ready is ignored and treated as 1.
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port opcode, input, 6 bits, instruction bits [31:26] taken from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1 bit, memory-access completion strobe.
REQ-006 SHALL have output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite and ALUSrcA, each 1 bit, as the datapath control strobes and selects.
REQ-007 SHALL have output ALUSrcB, 2 bits (00 reg B, 01 const 4, 10 sign-extended imm, 11 imm<<2).
REQ-008 SHALL have output Aluop, 2 bits, driving the ALU control decoder: 00 add, 01 subtract, 10 use funct field, 11 ORI.
REQ-009 SHALL have output PCSource, 2 bits (00 ALU result, 01 ALUOut, 10 jump target).
REQ-010 SHALL have output illegal_op, 1 bit, a one-cycle pulse on an unsupported opcode.
REQ-011 SHALL have output state_dbg, 4 bits, the current state encoding.

Function
REQ-012 SHALL be a Moore FSM with these states and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, ORIEX=12, ORIWB=13, JUMP=14; outputs decode from state only, except the gated strobes in REQ-014/015.
REQ-013 SHALL drive every unlisted output to 0 in each state.
REQ-014 SHALL, in FETCH, drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, Aluop=00 and PCSource=00, and drive IRWrite=PCWrite=1 only in the cycle mem_ready=1, then go to DECODE; while mem_ready=0 it SHALL hold FETCH.
REQ-015 SHALL, in MEMRD, drive MemRead=1 and IorD=1 and hold until mem_ready=1, then go to MEMWB; in MEMWR it SHALL drive MemWrite=1 and IorD=1 and hold until mem_ready=1, then go to FETCH.
REQ-016 SHALL, in DECODE, drive ALUSrcA=0, ALUSrcB=11 and Aluop=00, then branch on opcode: 000000 to EXEC, 100011/101011 to MEMADR, 000100 to BRANCH, 001000 to ADDIEX, 001101 to ORIEX, 000010 to JUMP, and any other opcode to FETCH with illegal_op=1 for that one cycle.
REQ-017 SHALL, in MEMADR, drive ALUSrcA=1, ALUSrcB=10 and Aluop=00, then go to MEMRD on opcode 100011 or to MEMWR otherwise.
REQ-018 SHALL, in MEMWB, drive RegWrite=1, MemtoReg=1 and RegDst=0, then go to FETCH.
REQ-019 SHALL, in EXEC, drive ALUSrcA=1, ALUSrcB=00 and Aluop=10, then go to ALUWB; ALUWB SHALL drive RegWrite=1, RegDst=1 and MemtoReg=0, then go to FETCH.
REQ-020 SHALL, in BRANCH, drive ALUSrcA=1, ALUSrcB=00, Aluop=01, PCWriteCond=1 and PCSource=01, then go to FETCH.
REQ-021 SHALL, in ADDIEX and ORIEX, drive ALUSrcA=1 and ALUSrcB=10, with Aluop=00 and 11 respectively, then go to ADDIWB or ORIWB.
REQ-022 SHALL, in ADDIWB and ORIWB, drive RegWrite=1, RegDst=0 and MemtoReg=0, then go to FETCH.
REQ-023 SHALL, in JUMP, drive PCWrite=1 and PCSource=10, then go to FETCH.
REQ-024 SHALL go from IDLE to FETCH unconditionally.
REQ-025 SHALL latch opcode only for the DECODE and MEMADR decisions; opcode changes in other states SHALL have no effect.
REQ-026 SHALL treat an unreachable state encoding (15) as IDLE and go to FETCH next.
REQ-027 SHALL produce these cycle counts from FETCH entry with zero memory wait: R-type 4, lw 5, sw 4, beq 3, addi 4, ori 4, j 3; each mem_ready=0 cycle in a memory state SHALL add exactly 1.

Reset
REQ-028 SHALL, when reset=1 at a clock edge, enter IDLE on that edge regardless of current state, including mid-wait in FETCH, MEMRD or MEMWR.
REQ-029 SHALL give reset priority over mem_ready and opcode.
REQ-030 SHALL drive all outputs to 0 and state_dbg=0 in IDLE; no write strobe (PCWrite, MemWrite, RegWrite, IRWrite) SHALL assert in the cycle after reset.

Verification
REQ-031 SHALL cover: reset, then mem_ready=1 and opcode=000000 -> states 0,1,2,7,8,1; Aluop=10 in EXEC; RegWrite=1 and RegDst=1 in ALUWB.
REQ-032 SHALL cover: opcode=100011 with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles with MemRead=1 and IorD=1; MemtoReg=1 in MEMWB; 7 cycles total.
REQ-033 SHALL cover: opcode=000100 -> BRANCH with Aluop=01, PCWriteCond=1 and PCSource=01; back in FETCH after 3 cycles.
REQ-034 SHALL cover: opcode=001101 -> ORIEX with Aluop=11 and ALUSrcB=10; ORIWB RegWrite=1.
REQ-035 SHALL cover: opcode=111111 in DECODE -> illegal_op=1 for exactly 1 cycle, next state FETCH, and no RegWrite or MemWrite.
REQ-036 SHALL cover: reset asserted while in MEMWR with mem_ready=0 -> IDLE next edge, MemWrite=0, then FETCH one cycle after reset drops.
